alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered pipeline stage directly downstream of sixty_four_bit_adder.
- Captures the adder's sum and c_out, derives N/Z/C/V condition flags, and presents result plus flags to writeback.
- Uses a valid/ready handshake with a 2-entry skid buffer, so it sustains one result per cycle with a registered in_ready.

Parameters:
- WIDTH, 64, datapath width; must match adder width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  adder inputs and outputs are stable and valid this cycle.
- in_ready  out  1  stage can accept a result this cycle; driven directly from a flop.
- sum  in  WIDTH  adder sum output.
- c_out  in  1  adder carry out.
- a_msb  in  1  MSB of adder operand a.
- b_msb  in  1  MSB of adder operand b, as applied to the adder (post-inversion for subtract).
- out_valid  out  1  out_result and out_flags are valid.
- out_ready  in  1  consumer accepts this cycle.
- out_result  out  WIDTH  captured sum.
- out_flags  out  4  {N,Z,C,V}.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, in_ready=1, out_result=0, out_flags=0.
  - Skid entry is cleared; state becomes EMPTY.
  - Reset overrides any handshake active in the same cycle; in-flight entries are dropped.
- Flag derivation is combinational on the inputs and captured with the data:
  - N = sum[WIDTH-1].
  - Z = (sum == 0).
  - C = c_out.
  - V = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb).
- Handshake events:
  - Input accept: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - out_result, out_flags and out_valid stay stable while out_valid=1 and out_ready=0.
- Latency: an accepted input appears on the outputs the next cycle (1 cycle).
- State machine (main register M, skid register S):
  - EMPTY (M empty, S empty):
    - accept -> ONE (load M).
    - no accept -> stay.
  - ONE (M valid, S empty):
    - accept and transfer -> ONE (M reloaded).
    - accept, no transfer -> FULL (load S, in_ready goes 0 next cycle).
    - transfer, no accept -> EMPTY.
    - neither -> stay.
  - FULL (M valid, S valid):
    - in_ready=0, so no accept is possible.
    - transfer -> ONE (M <= S, S cleared, in_ready goes 1 next cycle).
    - no transfer -> stay, holding both entries.
- in_ready = !S_valid, registered. It may be 1 while M is valid and stalled; the skid entry absorbs that extra beat.
- Ordering: strictly FIFO; no entry is dropped or duplicated outside reset.
- in_valid while in_ready=0: ignored; the upstream must hold its data.
- Arithmetic: no width extension; Z compares all WIDTH bits; V uses signed two's-complement rules.

Decomposition:
- Shared package alu_pkg holds:
  - constant ALU_WIDTH=64;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - typedef alu_flags_t (4-bit packed struct);
  - typedef alu_result_t {WIDTH data, alu_flags_t flags}.
- One natural sub-module, alu_flag_gen: combinational flag derivation, reusable by other execute units.
- The skid-buffer control stays inline.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles.
  - Response: out_valid=0, in_ready=1, out_result=0, out_flags=0.
- Single beat:
  - Stimulus: sum=0, c_out=1, a_msb=1, b_msb=1, in_valid for 1 cycle, out_ready=1.
  - Response next cycle: out_result=0, flags N=0 Z=1 C=1 V=1, out_valid=1 for exactly 1 cycle.
- Signed overflow:
  - Stimulus: sum=64'h8000_0000_0000_0000, c_out=0, a_msb=0, b_msb=0.
  - Response: flags N=1 Z=0 C=0 V=1.
- Back-pressure:
  - Stimulus: out_ready=0 while beats 0x11, 0x22, 0x33 are offered back-to-back.
  - Response: 0x11 and 0x22 accepted; in_ready=0 from the cycle after 0x22; 0x33 held upstream; out_result stays 0x11.
  - Then out_ready=1: outputs 0x11, 0x22, 0x33 on consecutive cycles.
- Full throughput:
  - Stimulus: 100 random beats with out_ready=1 constantly.
  - Response: in_ready stays 1; each output matches an adder+reference-flags model with 1-cycle latency; zero mismatches.
- Reset mid-operation:
  - Stimulus: reach FULL, assert rst for 1 cycle with out_ready=1.
  - Response: next cycle out_valid=0, in_ready=1; no stale beat ever appears on the outputs.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, condition-flag layout and result bundle.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Field order matches the FLAG_* indices: {N,Z,C,V}
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] data;
    alu_flags_t           flags;
  } alu_result_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V derivation from an adder result; shareable by other execute units.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] sum,
  input  logic             c_out,
  input  logic             a_msb,
  input  logic             b_msb,
  output alu_flags_t       flags
);

  logic [3:0] flag_vec;

  // Overflow: operands share a sign and the result sign differs from it
  always_comb begin
    flag_vec         = '0;
    flag_vec[FLAG_N] = sum[WIDTH-1];
    flag_vec[FLAG_Z] = (sum == '0);
    flag_vec[FLAG_C] = c_out;
    flag_vec[FLAG_V] = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
  end

  assign flags = alu_flags_t'(flag_vec);

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage after the adder: captures sum plus flags behind a 2-entry skid buffer.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | main and skid entries empty, out_valid=0
// ST_ONE   | main entry valid, skid empty, in_ready=1
// ST_FULL  | main and skid valid, in_ready=0 until a transfer
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             c_out,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state;
  logic             in_ready_q;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] s_data;
  alu_flags_t       m_flags;
  alu_flags_t       s_flags;
  alu_flags_t       in_flags;
  logic             accept;
  logic             xfer;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .sum   (sum),
    .c_out (c_out),
    .a_msb (a_msb),
    .b_msb (b_msb),
    .flags (in_flags)
  );

  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      m_data     <= '0;
      m_flags    <= '0;
      s_data     <= '0;
      s_flags    <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            m_data  <= sum;
            m_flags <= in_flags;
            state   <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && xfer) begin
            m_data  <= sum;
            m_flags <= in_flags;
          end else if (accept) begin
            // Consumer stalled: park the extra beat and close in_ready
            s_data     <= sum;
            s_flags    <= in_flags;
            in_ready_q <= 1'b0;
            state      <= ST_FULL;
          end else if (xfer) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            m_data     <= s_data;
            m_flags    <= s_flags;
            s_data     <= '0;
            s_flags    <= '0;
            in_ready_q <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state != ST_EMPTY);
  assign out_result = m_data;
  assign out_flags  = m_flags;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed handshake cases plus random full-rate traffic.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int W = ALU_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         a_msb;
  logic         b_msb;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;

  int n_vec = 0;
  int n_err = 0;
  logic [W+3:0] exp_q[$];

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum        (sum),
    .c_out      (c_out),
    .a_msb      (a_msb),
    .b_msb      (b_msb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  task automatic check(input string tag, input logic [W+3:0] got, input logic [W+3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {sum, N, Z, C, V}
  function automatic logic [W+3:0] ref_beat(input logic [W-1:0] s, input logic c,
                                            input logic am, input logic bm);
    logic n, z, v;
    n = s[W-1];
    z = (s == 64'd0);
    v = (am == bm) && (s[W-1] != am);
    return {s, n, z, c, v};
  endfunction

  // Monitor at the falling edge: outputs settled, handshake values match the next rising edge
  always @(negedge clk) begin
    logic [W+3:0] e;
    if (rst === 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {4'd0, out_result}, '0);
        end else begin
          e = exp_q.pop_front();
          check("result", {4'd0, out_result}, {4'd0, e[W+3:4]});
          check("flags", {{W{1'b0}}, out_flags}, {{W{1'b0}}, e[3:0]});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_beat(sum, c_out, a_msb, b_msb));
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge with in_valid still 1
  task automatic send(input logic [W-1:0] s, input logic c, input logic am, input logic bm);
    logic acc;
    in_valid = 1'b1; sum = s; c_out = c; a_msb = am; b_msb = bm;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) return;
    end
    check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [W:0]   full;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sum = '0; c_out = 1'b0; a_msb = 1'b0; b_msb = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", out_result, 0);
    check("rst_flags", out_flags, 0);
    @(posedge clk); #1;

    // Single beat, zero with carry and overflow flags set
    out_ready = 1'b1;
    send(64'd0, 1'b1, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("single_valid", out_valid, 1);
    check("single_result", out_result, 0);
    check("single_flags", out_flags, 4'b0111);
    @(negedge clk);
    check("single_valid_drop", out_valid, 0);
    @(posedge clk); #1;

    // Signed overflow: positive + positive gives a negative result
    send(64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("ovf_flags", out_flags, 4'b1001);
    @(posedge clk); #1;
    idle(1);

    // Back-pressure: third beat must be held upstream
    out_ready = 1'b0;
    send(64'h11, 1'b0, 1'b0, 1'b0);
    send(64'h22, 1'b0, 1'b0, 1'b0);
    sum = 64'h33;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_result", out_result, 64'h11);
      check("bp_hold_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_0", out_result, 64'h11);
    @(negedge clk);
    check("drain_1", out_result, 64'h22);
    check("drain_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_2", out_result, 64'h33);
    check("drain_2_valid", out_valid, 1);
    @(posedge clk); #1;
    idle(2);

    // Full throughput with random adder traffic
    for (int i = 0; i < 100; i++) begin
      a = {$urandom, $urandom};
      b = (i % 10 == 3) ? (~a + 64'd1) : {$urandom, $urandom};
      if (i % 17 == 5) begin a = 64'h7fff_ffff_ffff_ffff; b = 64'd1; end
      full = {1'b0, a} + {1'b0, b};
      in_valid = 1'b1; sum = full[W-1:0]; c_out = full[W]; a_msb = a[W-1]; b_msb = b[W-1];
      @(negedge clk);
      check("tp_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    idle(3);
    check("tp_queue_empty", exp_q.size(), 0);

    // Reset while FULL: nothing stale may emerge
    out_ready = 1'b0;
    send(64'hAA, 1'b0, 1'b0, 1'b0);
    send(64'hBB, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    idle(4);
    send(64'hCC, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_result", out_result, 64'hCC);
    @(posedge clk); #1;
    idle(3);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
